// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Walks a pixel position (h, v) across the full raster once per pix_en
// cycle. Each advance registers the sync, visible-region and pulse outputs
// decoded from the position before the advance, so the outputs trail the
// counters by one board_clk cycle.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   XW       = 10,
   parameter int   YW       = 10
) (
   input  logic          board_clk,
   input  logic          rst,
   input  logic          pix_en,
   output logic          hs,
   output logic          vs,
   output logic          active,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Region boundaries; every one is below the total, so it fits the counter.
   localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] H_ACT_END  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [XW-1:0] H_ONE      = XW'(1);
   localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] V_ACT_END  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [YW-1:0] V_ONE      = YW'(1);

   logic [XW-1:0] h_cnt_q, h_cnt_d;
   logic [YW-1:0] v_cnt_q, v_cnt_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          active_q, active_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   // Set once the first frame_start after reset has gone out; that frame
   // is the one in progress, not a completed one, so it is not counted.
   logic          frame_seen_q, frame_seen_d;
   logic          h_vis, v_vis;

   // Next position and decode of the current position; everything holds
   // and the pulses drop while pix_en is low.
   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      active_d      = active_q;
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      frame_seen_d  = frame_seen_q;
      h_vis         = (h_cnt_q < H_ACT_END);
      v_vis         = (v_cnt_q < V_ACT_END);
      if (pix_en) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_ONE;
         end else begin
            h_cnt_d = h_cnt_q + H_ONE;
         end
         active_d      = h_vis && v_vis;
         x_d           = (h_vis && v_vis) ? h_cnt_q : '0;
         y_d           = (h_vis && v_vis) ? v_cnt_q : '0;
         hs_d          = (h_cnt_q >= H_SYNC_BEG && h_cnt_q < H_SYNC_END) ? HS_POL : ~HS_POL;
         vs_d          = (v_cnt_q >= V_SYNC_BEG && v_cnt_q < V_SYNC_END) ? VS_POL : ~VS_POL;
         line_start_d  = (h_cnt_q == '0);
         frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
         if (frame_start_d) begin
            if (frame_seen_q) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
            frame_seen_d = 1'b1;
         end
      end
   end

   // State and output registers; reset returns to the top-left, sync idle.
   always_ff @(posedge board_clk) begin
      if (rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hs_q          <= ~HS_POL;
         vs_q          <= ~VS_POL;
         active_q      <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= 8'd0;
         frame_seen_q  <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         active_q      <= active_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
         frame_seen_q  <= frame_seen_d;
      end
   end

   assign hs          = hs_q;
   assign vs          = vs_q;
   assign active      = active_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one instance with the 640x480 defaults and one
// with a tiny 8x6 raster and active-high syncs, both on shared rst/pix_en.
// A raster model keyed on a linear pixel index predicts every output.
module tb_vga_timing_gen;

   logic board_clk = 1'b0;
   logic rst       = 1'b1;
   logic pix_en    = 1'b0;

   always #5 board_clk = ~board_clk;

   logic       hs0, vs0, act0, ls0, fs0;
   logic [9:0] x0, y0;
   logic [7:0] fc0;
   logic       hs1, vs1, act1, ls1, fs1;
   logic [3:0] x1;
   logic [2:0] y1;
   logic [7:0] fc1;

   vga_timing_gen dut0 (
      .board_clk(board_clk), .rst(rst), .pix_en(pix_en),
      .hs(hs0), .vs(vs0), .active(act0), .x(x0), .y(y0),
      .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .XW(4), .YW(3)
   ) dut1 (
      .board_clk(board_clk), .rst(rst), .pix_en(pix_en),
      .hs(hs1), .vs(vs1), .active(act1), .x(x1), .y(y1),
      .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
   );

   int P_HA[2] = '{640, 4};
   int P_HF[2] = '{16, 1};
   int P_HS[2] = '{96, 2};
   int P_HB[2] = '{48, 1};
   int P_VA[2] = '{480, 3};
   int P_VF[2] = '{10, 1};
   int P_VS[2] = '{2, 1};
   int P_VB[2] = '{33, 1};
   bit P_HP[2] = '{1'b0, 1'b1};
   bit P_VP[2] = '{1'b0, 1'b1};

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int mode     = 3;
   int fs_n     = 0;
   bit armed    = 1'b0;

   int m_pos[2];
   bit m_started[2];
   bit e_hs[2], e_vs[2], e_act[2], e_ls[2], e_fs[2];
   int e_x[2], e_y[2], e_fc[2];

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Raster model: position is a linear pixel index within the frame.
   task automatic model_step(input int k);
      int ht, vt, h, v, hsb, vsb;
      ht = P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k];
      vt = P_VA[k] + P_VF[k] + P_VS[k] + P_VB[k];
      if (rst) begin
         m_pos[k] = 0; m_started[k] = 0;
         e_hs[k] = !P_HP[k]; e_vs[k] = !P_VP[k]; e_act[k] = 0;
         e_x[k] = 0; e_y[k] = 0; e_ls[k] = 0; e_fs[k] = 0; e_fc[k] = 0;
      end else if (pix_en) begin
         h = m_pos[k] % ht;
         v = m_pos[k] / ht;
         hsb = P_HA[k] + P_HF[k];
         vsb = P_VA[k] + P_VF[k];
         e_act[k] = (h < P_HA[k]) && (v < P_VA[k]);
         e_x[k] = e_act[k] ? h : 0;
         e_y[k] = e_act[k] ? v : 0;
         e_hs[k] = (h >= hsb && h < hsb + P_HS[k]) ? P_HP[k] : !P_HP[k];
         e_vs[k] = (v >= vsb && v < vsb + P_VS[k]) ? P_VP[k] : !P_VP[k];
         e_ls[k] = (h == 0);
         e_fs[k] = (m_pos[k] == 0);
         if (e_fs[k]) begin
            if (m_started[k]) e_fc[k] = (e_fc[k] + 1) % 256;
            m_started[k] = 1;
         end
         m_pos[k] = (m_pos[k] + 1) % (ht * vt);
      end else begin
         e_ls[k] = 0;
         e_fs[k] = 0;
      end
   endtask

   task automatic check_dut(input int k, input logic hs, input logic vs, input logic act,
                            input int x, input int y, input logic ls, input logic fs, input int fc);
      n_checks++;
      if (hs !== e_hs[k] || vs !== e_vs[k] || act !== e_act[k] || x != e_x[k] || y != e_y[k] ||
          ls !== e_ls[k] || fs !== e_fs[k] || fc != e_fc[k]) begin
         n_errors++;
         if (n_errors <= 20)
            $display("FAIL model dut%0d cycle %0d: got hs=%b vs=%b act=%b x=%0d y=%0d ls=%b fs=%b fc=%0d, expected hs=%b vs=%b act=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
                     k, cyc, hs, vs, act, x, y, ls, fs, fc,
                     e_hs[k], e_vs[k], e_act[k], e_x[k], e_y[k], e_ls[k], e_fs[k], e_fc[k]);
      end
   endtask

   // Model advances on the same edge as the DUT.
   initial forever begin
      @(posedge board_clk);
      cyc++;
      if (rst) fs_n = 0;
      model_step(0);
      model_step(1);
      armed = 1'b1;
   end

   // Compare every cycle, plus frame_cnt pinned at chosen frame numbers.
   initial forever begin
      @(negedge board_clk);
      if (armed) begin
         check_dut(0, hs0, vs0, act0, int'(x0), int'(y0), ls0, fs0, int'(fc0));
         check_dut(1, hs1, vs1, act1, int'(x1), int'(y1), ls1, fs1, int'(fc1));
         if (fs1) begin
            fs_n++;
            if (fs_n == 1)   chk("fcnt_frame1", int'(fc1), 0);
            if (fs_n == 2)   chk("fcnt_frame2", int'(fc1), 1);
            if (fs_n == 256) chk("fcnt_frame256", int'(fc1), 255);
            if (fs_n == 257) chk("fcnt_wrap", int'(fc1), 0);
         end
      end
   end

   task automatic tick();
      @(negedge board_clk);
      case (mode)
         0:       pix_en = 1'b1;
         1:       pix_en = ~pix_en;
         2:       pix_en = ((cyc % 3) != 1);
         default: pix_en = 1'b0;
      endcase
   endtask

   function automatic bit cond(input int which);
      case (which)
         0:       return ls0;
         1:       return fs1;
         2:       return !hs0;
         3:       return hs1;
         4:       return vs1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input string name, input int which, output int t);
      t = -1;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (cond(which)) begin
            t = cyc;
            return;
         end
      end
      n_checks++;
      n_errors++;
      $display("FAIL %s: event not seen within 5000 cycles", name);
   endtask

   task automatic run_len(input int which, output int n);
      n = 1;
      for (int i = 0; i < 2000; i++) begin
         tick();
         if (cond(which)) n++;
         else return;
      end
   endtask

   initial begin
      int ta, tb, tc, tv, la, lb, h0, n, t_rel;
      rst = 1'b1;
      mode = 3;
      repeat (3) tick();
      chk("rst_hs0", int'(hs0), 1);
      chk("rst_vs0", int'(vs0), 1);
      chk("rst_hs1", int'(hs1), 0);
      chk("rst_act0", int'(act0), 0);
      chk("rst_fc1", int'(fc1), 0);

      // Release reset with pix_en high: first decode is (0,0).
      rst = 1'b0;
      mode = 0;
      pix_en = 1'b1;
      tick();
      t_rel = cyc;
      chk("first_fs0", int'(fs0), 1);
      chk("first_ls0", int'(ls0), 1);
      chk("first_act0", int'(act0), 1);
      chk("first_x0", int'(x0), 0);
      chk("first_fc0", int'(fc0), 0);

      wait_for("fs1_a", 1, ta);
      wait_for("fs1_b", 1, tb);
      chk("small_frame_period", tb - ta, 48);
      wait_for("hs1_rise", 3, tc);
      chk("small_hs_offset", tc - tb, 5);
      run_len(3, n);
      chk("small_hs_width", n, 2);
      wait_for("vs1_rise", 4, tv);
      chk("small_vs_offset", tv - tb, 32);
      run_len(4, n);
      chk("small_vs_width", n, 8);

      wait_for("ls0_a", 0, la);
      wait_for("ls0_b", 0, lb);
      chk("line_period", lb - la, 800);
      wait_for("hs0_fall", 2, h0);
      chk("hs0_offset", h0 - lb, 656);
      run_len(2, n);
      chk("hs0_width", n, 96);

      while (cyc - t_rel < 257 * 48 + 5) tick();
      chk("small_frames_seen", fs_n, 258);

      // Reset in the middle of a visible line at h=300 on the default raster.
      wait_for("ls0_mid", 0, la);
      repeat (299) tick();
      chk("pre_rst_x0", int'(x0), 299);
      rst = 1'b1;
      tick();
      chk("midrst_act0", int'(act0), 0);
      chk("midrst_x0", int'(x0), 0);
      chk("midrst_y0", int'(y0), 0);
      chk("midrst_hs0", int'(hs0), 1);
      chk("midrst_vs0", int'(vs0), 1);
      chk("midrst_ls0", int'(ls0), 0);
      chk("midrst_fc0", int'(fc0), 0);
      chk("midrst_hs1", int'(hs1), 0);
      chk("midrst_fc1", int'(fc1), 0);
      rst = 1'b0;
      tick();
      chk("restart_fs0", int'(fs0), 1);
      chk("restart_x0", int'(x0), 0);
      chk("restart_y0", int'(y0), 0);
      chk("restart_act0", int'(act0), 1);
      chk("restart_fc0", int'(fc0), 0);
      chk("restart_fs1", int'(fs1), 1);

      // pix_en every second cycle.
      mode = 1;
      wait_for("ls0_half_a", 0, la);
      wait_for("ls0_half_b", 0, lb);
      chk("line_period_half", lb - la, 1600);
      tick();
      chk("ls_width_half", int'(ls0), 0);

      // Irregular enable pattern, checked by the model only.
      mode = 2;
      repeat (600) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
